// File: rtl/sprite_drawer.sv
// Sprite plotting engine: restores background or draws a character sprite,
// streaming one pixel per clock to the VGA adapter.
module sprite_drawer #(
  parameter int                  SPRITE_W    = 8,
  parameter int                  SPRITE_H    = 8,
  parameter int                  CHAR_ADDR_W = 6,
  parameter int                  COLOUR_W    = 9,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = 9'b111_000_111
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   drawBG,
  input  logic                   drawChar,
  input  logic [8:0]             xCoordinate,
  input  logic [7:0]             yCoordinate,
  output logic [CHAR_ADDR_W-1:0] charAddr,
  input  logic [COLOUR_W-1:0]    charData,
  output logic [16:0]            bgAddr,
  input  logic [COLOUR_W-1:0]    bgData,
  output logic [8:0]             vgaX,
  output logic [7:0]             vgaY,
  output logic [COLOUR_W-1:0]    colour,
  output logic                   plot,
  output logic                   doneBG,
  output logic                   doneChar,
  output logic [2:0]             state_dbg
);

  // Handshake: drawBG/drawChar are levels held by the requester until the
  // matching one-cycle done pulse; the served line must then drop before
  // the engine returns to IDLE, so a held request never causes a redraw.

  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    FLUSH   = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                 state;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic [CHAR_ADDR_W-1:0] idx;
  logic [8:0]             x_lat;
  logic [7:0]             y_lat;
  logic                   type_bg;

  // Plot-stage pipeline registers, one cycle behind the address stage
  logic                   s1_valid;
  logic                   s1_clip;
  logic [8:0]             s1_px;
  logic [7:0]             s1_py;

  logic [9:0]             px;
  logic [9:0]             py;
  logic                   clip;
  logic [16:0]            bg_lin;
  logic                   last_col;
  logic                   last_pix;

  always_comb begin
    px       = {1'b0, x_lat} + 10'(col);
    py       = {2'b00, y_lat} + 10'(row);
    clip     = (px >= 10'd320) || (py >= 10'd240);
    // py*320 + px without a multiplier
    bg_lin   = ({7'd0, py} << 8) + ({7'd0, py} << 6) + {7'd0, px};
    last_col = (col == COL_W'(SPRITE_W - 1));
    last_pix = last_col && (row == ROW_W'(SPRITE_H - 1));
  end

  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      idx      <= '0;
      x_lat    <= '0;
      y_lat    <= '0;
      type_bg  <= 1'b0;
      s1_valid <= 1'b0;
      s1_clip  <= 1'b0;
      s1_px    <= '0;
      s1_py    <= '0;
      charAddr <= '0;
      bgAddr   <= '0;
      vgaX     <= '0;
      vgaY     <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      doneBG   <= 1'b0;
      doneChar <= 1'b0;
    end else begin
      s1_valid <= 1'b0;
      doneBG   <= 1'b0;
      doneChar <= 1'b0;

      // ROM data for the address issued last cycle is valid now
      plot <= s1_valid && !s1_clip && (type_bg || (charData != TRANSPARENT));
      if (s1_valid) begin
        vgaX   <= s1_px;
        vgaY   <= s1_py;
        colour <= type_bg ? bgData : charData;
      end

      case (state)
        IDLE: begin
          if (drawBG || drawChar) begin
            x_lat   <= xCoordinate;
            y_lat   <= yCoordinate;
            type_bg <= drawBG;
            col     <= '0;
            row     <= '0;
            idx     <= '0;
            state   <= SCAN;
          end
        end

        SCAN: begin
          s1_valid <= 1'b1;
          s1_clip  <= clip;
          s1_px    <= px[8:0];
          s1_py    <= py[7:0];
          charAddr <= idx;
          bgAddr   <= clip ? 17'd0 : bg_lin;
          idx      <= idx + CHAR_ADDR_W'(1);
          if (last_pix) begin
            state <= FLUSH;
          end else if (last_col) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end

        FLUSH: state <= DONE;

        DONE: begin
          if (type_bg) doneBG   <= 1'b1;
          else         doneChar <= 1'b1;
          state <= RELEASE;
        end

        RELEASE: begin
          if (type_bg ? !drawBG : !drawChar) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_drawer.sv
// Bench for sprite_drawer: directed table, multi-cycle corner sequences and
// randomized draws checked against a pixel-level reference model.
module tb_sprite_drawer;

  localparam int SW = 8;
  localparam int SH = 8;
  localparam int N  = SW * SH;
  localparam logic [8:0] TRANSP = 9'b111_000_111;

  logic       clock;
  logic       reset;
  logic       drawBG;
  logic       drawChar;
  logic [8:0] xCoordinate;
  logic [7:0] yCoordinate;
  logic [5:0] charAddr;
  logic [8:0] charData;
  logic [16:0] bgAddr;
  logic [8:0] bgData;
  logic [8:0] vgaX;
  logic [7:0] vgaY;
  logic [8:0] colour;
  logic       plot;
  logic       doneBG;
  logic       doneChar;
  logic [2:0] state_dbg;

  logic [8:0] char_rom [N];

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    bit         plot;
    bit         clipped;
    int         px;
    int         py;
    int         bgaddr;
    logic [8:0] colour;
  } pix_t;

  typedef struct {
    bit bg;
    int x;
    int y;
    int plots;
  } vec_t;

  function automatic logic [8:0] bg_fn(input int a);
    return 9'((a * 37 + 11) % 512);
  endfunction

  assign charData = char_rom[charAddr];
  assign bgData   = bg_fn(int'(bgAddr));

  sprite_drawer dut (
    .clock       (clock),
    .reset       (reset),
    .drawBG      (drawBG),
    .drawChar    (drawChar),
    .xCoordinate (xCoordinate),
    .yCoordinate (yCoordinate),
    .charAddr    (charAddr),
    .charData    (charData),
    .bgAddr      (bgAddr),
    .bgData      (bgData),
    .vgaX        (vgaX),
    .vgaY        (vgaY),
    .colour      (colour),
    .plot        (plot),
    .doneBG      (doneBG),
    .doneChar    (doneChar),
    .state_dbg   (state_dbg)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Reference model: what pixel i of a sprite at (x,y) should produce
  function automatic pix_t model_pixel(input bit bg, input int x, input int y, input int i);
    pix_t p;
    int c = i % SW;
    int r = i / SW;
    p.px      = x + c;
    p.py      = y + r;
    p.clipped = (p.px >= 320) || (p.py >= 240);
    p.bgaddr  = p.clipped ? 0 : p.py * 320 + p.px;
    p.colour  = bg ? bg_fn(p.bgaddr) : char_rom[i];
    p.plot    = !p.clipped && (bg || char_rom[i] != TRANSP);
    return p;
  endfunction

  function automatic int model_count(input bit bg, input int x, input int y);
    int n = 0;
    for (int i = 0; i < N; i++) begin
      pix_t p = model_pixel(bg, x, y, i);
      if (p.plot) n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called before the capture edge; follows the whole scan through done.
  task automatic check_scan(input bit bg, input int x, input int y, input bit wiggle,
                            output int nplots);
    pix_t p;
    nplots = 0;
    @(posedge clock);
    for (int k = 1; k <= N + 3; k++) begin
      @(posedge clock); #1;
      if (k <= N) begin
        p = model_pixel(bg, x, y, k - 1);
        check("char_addr", 32'(charAddr), 32'(k - 1));
        check("bg_addr", 32'(bgAddr), 32'(p.bgaddr));
      end
      if (k >= 2 && k <= N + 1) begin
        p = model_pixel(bg, x, y, k - 2);
        check("plot", 32'(plot), 32'(p.plot));
        if (p.plot) begin
          check("vga_x", 32'(vgaX), 32'(p.px));
          check("vga_y", 32'(vgaY), 32'(p.py));
          check("colour", 32'(colour), 32'(p.colour));
        end
      end else begin
        check("plot_outside_scan", 32'(plot), 32'd0);
      end
      if (plot) nplots++;
      check("done_bg", 32'(doneBG), 32'(bg && k == N + 2));
      check("done_char", 32'(doneChar), 32'(!bg && k == N + 2));
      if (wiggle && k < N) begin
        xCoordinate = 9'($urandom_range(0, 319));
        yCoordinate = 8'($urandom_range(0, 239));
      end
    end
  endtask

  task automatic hold_check(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clock); #1;
      check("held_plot", 32'(plot), 32'd0);
      check("held_done_bg", 32'(doneBG), 32'd0);
      check("held_done_char", 32'(doneChar), 32'd0);
    end
  endtask

  task automatic run_draw(input bit bg, input int x, input int y, input bit wiggle,
                          output int nplots);
    @(negedge clock);
    xCoordinate = 9'(x);
    yCoordinate = 8'(y);
    drawBG      = bg;
    drawChar    = !bg;
    check_scan(bg, x, y, wiggle, nplots);
    check("plot_count", 32'(nplots), 32'(model_count(bg, x, y)));
    hold_check(4);
    @(negedge clock);
    drawBG   = 1'b0;
    drawChar = 1'b0;
    @(posedge clock);
  endtask

  vec_t tbl [7];

  initial begin
    int np;
    int sx;
    int sy;
    pix_t p;

    tbl[0] = '{bg: 1'b1, x: 95,  y: 221, plots: 64};
    tbl[1] = '{bg: 1'b0, x: 126, y: 68,  plots: 63};
    tbl[2] = '{bg: 1'b1, x: 316, y: 236, plots: 16};
    tbl[3] = '{bg: 1'b1, x: 312, y: 232, plots: 64};
    tbl[4] = '{bg: 1'b0, x: 319, y: 239, plots: 1};
    tbl[5] = '{bg: 1'b0, x: 0,   y: 0,   plots: 63};
    tbl[6] = '{bg: 1'b1, x: 319, y: 100, plots: 8};

    for (int i = 0; i < N; i++) char_rom[i] = 9'(i * 7 + 3);
    char_rom[5] = TRANSP;

    // Clock/reset: reset with drawBG high must not start a draw
    reset       = 1'b1;
    drawBG      = 1'b1;
    drawChar    = 1'b0;
    xCoordinate = 9'd10;
    yCoordinate = 8'd10;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      check("rst_plot", 32'(plot), 32'd0);
      check("rst_done_bg", 32'(doneBG), 32'd0);
      check("rst_done_char", 32'(doneChar), 32'd0);
      check("rst_vga_x", 32'(vgaX), 32'd0);
      check("rst_vga_y", 32'(vgaY), 32'd0);
      check("rst_colour", 32'(colour), 32'd0);
      check("rst_char_addr", 32'(charAddr), 32'd0);
      check("rst_bg_addr", 32'(bgAddr), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
    end
    @(negedge clock);
    reset  = 1'b0;
    drawBG = 1'b0;
    hold_check(2);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_draw(tbl[i].bg, tbl[i].x, tbl[i].y, 1'b0, np);
      check("table_plots", 32'(np), 32'(tbl[i].plots));
    end

    // Simultaneous requests: BG wins, then char once BG drops
    @(negedge clock);
    xCoordinate = 9'd40;
    yCoordinate = 8'd50;
    drawBG      = 1'b1;
    drawChar    = 1'b1;
    check_scan(1'b1, 40, 50, 1'b0, np);
    check("simul_bg_plots", 32'(np), 32'd64);
    hold_check(3);
    @(negedge clock);
    drawBG = 1'b0;
    @(posedge clock);
    check_scan(1'b0, 40, 50, 1'b0, np);
    check("simul_char_plots", 32'(np), 32'd63);
    hold_check(3);
    @(negedge clock);
    drawChar = 1'b0;
    @(posedge clock);

    // Reset in cycle 30 of a character scan
    @(negedge clock);
    xCoordinate = 9'd200;
    yCoordinate = 8'd100;
    drawChar    = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 29; k++) begin
      @(posedge clock); #1;
      if (k >= 2) begin
        p = model_pixel(1'b0, 200, 100, k - 2);
        check("pre_reset_plot", 32'(plot), 32'(p.plot));
      end
    end
    @(negedge clock);
    reset    = 1'b1;
    drawChar = 1'b0;
    @(posedge clock); #1;
    check("midrst_plot", 32'(plot), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    check("midrst_char_addr", 32'(charAddr), 32'd0);
    check("midrst_bg_addr", 32'(bgAddr), 32'd0);
    check("midrst_vga_x", 32'(vgaX), 32'd0);
    check("midrst_colour", 32'(colour), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    hold_check(80);
    run_draw(1'b0, 5, 7, 1'b0, np);

    // Randomized draws with random ROM contents and mid-scan input changes
    for (int i = 0; i < N; i++)
      char_rom[i] = ($urandom_range(0, 7) == 0) ? TRANSP : 9'($urandom_range(0, 511));
    for (int t = 0; t < 16; t++) begin
      sx = ($urandom_range(0, 2) == 0) ? $urandom_range(305, 319) : $urandom_range(0, 319);
      sy = ($urandom_range(0, 2) == 0) ? $urandom_range(225, 239) : $urandom_range(0, 239);
      run_draw(1'($urandom_range(0, 1)), sx, sy, 1'b1, np);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sprite_drawer.md
# sprite_drawer

Pixel-plotting engine on the responding end of the movement controller's draw handshake. On a `drawBG` request it restores the background under the sprite's bounding box from the background ROM. On a `drawChar` request it draws the character sprite from the character ROM at the latched coordinates. It streams one pixel per clock to the VGA adapter and answers each request with a one-cycle `doneBG` / `doneChar` pulse.

## Interface
- `SPRITE_W`, default 8: sprite width in pixels.
- `SPRITE_H`, default 8: sprite height in pixels.
- `CHAR_ADDR_W`, default 6: character ROM address width; `SPRITE_W*SPRITE_H <= 2^CHAR_ADDR_W`.
- `COLOUR_W`, default 9: pixel colour width.
- `TRANSPARENT`, default 9'b111_000_111: character colour that is never plotted.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `drawBG`  in  1: background-restore request (level, held until `doneBG`).
- `drawChar`  in  1: character-draw request (level, held until `doneChar`).
- `xCoordinate`  in  9: sprite top-left X, 0..319.
- `yCoordinate`  in  8: sprite top-left Y, 0..239.
- `charAddr`  out  CHAR_ADDR_W: character ROM address.
- `charData`  in  COLOUR_W: character ROM data, valid 1 cycle after `charAddr`.
- `bgAddr`  out  17: background ROM address.
- `bgData`  in  COLOUR_W: background ROM data, valid 1 cycle after `bgAddr`.
- `vgaX`  out  9: plot X.
- `vgaY`  out  8: plot Y.
- `colour`  out  COLOUR_W: plot colour.
- `plot`  out  1: write strobe to the VGA adapter.
- `doneBG`  out  1: one-cycle completion pulse for `drawBG`.
- `doneChar`  out  1: one-cycle completion pulse for `drawChar`.

## Operation
- **States:**
  - `IDLE`: sample requests.
  - `SCAN`: issue pixel addresses.
  - `FLUSH`: last ROM read returns.
  - `DONE`: pulse done.
  - `RELEASE`: wait for the served request to drop.
- **Request capture:** in `IDLE`, `drawBG` has priority over `drawChar`. The state machine latches x, y and the request type, clears `col` and `row`, and goes to `SCAN`.
- **Scan order:** row-major, `col` fastest.
  - Counters: `col` 0..SPRITE_W-1, `row` 0..SPRITE_H-1.
  - After `col`=SPRITE_W-1 and `row`=SPRITE_H-1 have been issued, go to `FLUSH`.
- **Pixel position:** px = x+col and py = y+row, computed 10 bits wide with no wrap.
- **Clipping:** a pixel is clipped when px>=320 or py>=240. A clipped pixel is never plotted but still takes its cycle; its `bgAddr` is 0.
- **Addresses:**
  - `charAddr` = row*SPRITE_W + col.
  - `bgAddr` = py*320 + px, implemented as (py<<8)+(py<<6)+px, 17 bits.
- **Plot stage:** one cycle behind the address stage.
  - `vgaX`/`vgaY` carry the delayed px/py; `colour` carries the ROM data of the served type.
  - `plot` = 1 when the pixel is not clipped and (type=BG or `charData` != TRANSPARENT).
- **Completion:**
  - `FLUSH` → `DONE`; `DONE` pulses the done line of the served type for 1 cycle, then goes to `RELEASE`.
  - `RELEASE` → `IDLE` once the served request line is 0; the other line is ignored here.
  - A request held high after done never triggers a redraw.
- **Mid-operation changes:** requests and coordinates that change mid-operation are ignored; the latched values rule until `IDLE`.
- **Reset:** reset in any state takes effect at the next edge.
  - State goes to `IDLE`, counters to 0.
  - All outputs go to 0 (`plot`, `doneBG`, `doneChar`, `vgaX`, `vgaY`, `colour`, `charAddr`, `bgAddr`).
  - A partial draw is abandoned with no done pulse.

## Timing
- Cycle 0 is the edge at which `IDLE` samples a request; N = SPRITE_W*SPRITE_H.
- Pixel i (0..N-1) address is presented in cycle 1+i; its `plot`, `vgaX`, `vgaY` and `colour` are registered for cycle 2+i.
- The last plot is in cycle N+1, and the done pulse is in cycle N+2. The default 8x8 sprite gives done in cycle 66.
- `plot` is 0 in every cycle outside 2..N+1.
- Back-to-back requests: the earliest new capture is the first cycle after `RELEASE` sees the served line low.
- Throughput: 1 pixel per clock, no stalls.

## Test plan
- **Reset:** assert `reset` with `drawBG`=1 for 2 cycles → all outputs 0, state `IDLE`, no plot.
- **Background restore:** `drawBG` at (95,221), held through done.
  - Cycle 2: first plot at (95,221), `bgAddr` 70815 issued in cycle 1.
  - Cycle 65: last plot at (102,228), address 73062.
  - Cycle 66: `doneBG` high for exactly 1 cycle.
  - 64 plots total; no second draw while `drawBG` stays high.
- **Character transparency:** `drawChar` at (126,68) with ROM word 5 = TRANSPARENT → 63 plots, none at (131,68), `colour` equals the ROM data on every plot, `doneChar` in cycle 66.
- **Clipping:** `drawBG` at (316,236) → exactly 16 plots (cols 0..3, rows 0..3), no `vgaX`>319 or `vgaY`>239 with `plot` high, `doneBG` still in cycle 66.
- **Simultaneous requests:** `drawBG` and `drawChar` rise together → BG scan first and `doneBG` in cycle 66. Then drop `drawBG` with `drawChar` still high → character scan starts and `doneChar` follows 66 cycles after its capture.
- **Reset mid-scan:** pulse `reset` in cycle 30 of a `drawChar` scan → `plot`=0 from the next cycle, `doneChar` never pulses. A new request then restarts at pixel 0 with first `charAddr` = 0.
